pipe_approx_adder: RTL and testbench

// - Parametrised, pipelined successor to the 16-bit ripple-carry adder used in the approximate CNN datapath.
// - Splits the WIDTH-bit carry chain into STAGES registered segments.
// - Selects per transaction between exact addition and lower-part-OR approximation (LOA) on the low APPROX_BITS bits.
// - Uses valid/ready handshakes on both sides, so it drops into the MAC accumulate path with backpressure.

---
 rtl/approx_adder_pkg.sv | 31 +++
 rtl/adder_seg.sv | 39 +++
 rtl/pipe_approx_adder.sv | 105 ++++++++++
 tb/tb_pipe_approx_adder.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/approx_adder_pkg.sv
// Shared types for the pipelined approximate adder: transaction mode, stage payload, LOA mask helper.
// Payload fields are sized for the widest supported datapath (LOA_MAX_W); narrower instances use the low bits.
package approx_adder_pkg;

  localparam int LOA_MAX_W = 64;

  typedef enum logic {
    MODE_EXACT = 1'b0,
    MODE_LOA   = 1'b1
  } add_mode_e;

  typedef struct packed {
    logic [LOA_MAX_W-1:0] a;
    logic [LOA_MAX_W-1:0] b;
    logic [LOA_MAX_W-1:0] y;
    logic                 carry;
    add_mode_e            mode;
    logic                 vld;
  } stage_t;

  // Bit i is set when bit i lies inside the low k approximate bits and below width.
  function automatic logic [LOA_MAX_W-1:0] loa_mask(input int k, input int width);
    logic [LOA_MAX_W-1:0] m;
    m = '0;
    for (int i = 0; i < LOA_MAX_W; i++) begin
      if (i < k && i < width) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/adder_seg.sv
// Combinational SEG-bit segment adder; bit i is OR-approximated when in LOA mode and BASE+i < APPROX_BITS.
// Zero latency, no handshake; carry out of an approximate bit is a&b (the LOA carry), never a ripple carry.
module adder_seg
  import approx_adder_pkg::*;
#(
  parameter int SEG         = 8,
  parameter int BASE        = 0,
  parameter int APPROX_BITS = 4
) (
  input  logic [SEG-1:0] a_seg,
  input  logic [SEG-1:0] b_seg,
  input  logic           cin,
  input  add_mode_e      mode,
  output logic [SEG-1:0] s_seg,
  output logic           cout
);

  localparam logic [LOA_MAX_W-1:0] APPROX_MASK = loa_mask(APPROX_BITS, BASE + SEG);

  logic [SEG:0] c;

  always_comb begin
    c     = '0;
    c[0]  = cin;
    s_seg = '0;
    for (int i = 0; i < SEG; i++) begin
      if (mode == MODE_LOA && APPROX_MASK[BASE+i]) begin
        s_seg[i] = a_seg[i] | b_seg[i];
        c[i+1]   = a_seg[i] & b_seg[i];
      end else begin
        s_seg[i] = a_seg[i] ^ b_seg[i] ^ c[i];
        c[i+1]   = (a_seg[i] & b_seg[i]) | (c[i] & (a_seg[i] ^ b_seg[i]));
      end
    end
  end

  assign cout = c[SEG];

endmodule

// File: rtl/pipe_approx_adder.sv
// Pipelined exact/LOA adder: STAGES carry segments, latency STAGES cycles, one result per cycle.
// Backpressure ripples combinationally from out_ready to in_ready; bubbles collapse, no skid buffer.
module pipe_approx_adder
  import approx_adder_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int STAGES      = 2,
  parameter int APPROX_BITS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             approx_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             cout
);

  localparam int SEG  = WIDTH / STAGES;
  localparam int LAST = STAGES - 1;

  stage_t src  [STAGES];
  stage_t st_d [STAGES];
  stage_t st_q [STAGES];

  logic [STAGES-1:0][SEG-1:0] seg_a;
  logic [STAGES-1:0][SEG-1:0] seg_b;
  logic [STAGES-1:0][SEG-1:0] seg_s;
  logic [STAGES-1:0]          seg_cin;
  logic [STAGES-1:0]          seg_cout;
  add_mode_e                  seg_mode [STAGES];
  logic [STAGES-1:0]          adv;

  // Stage 0 consumes the port operands; stage k consumes the payload registered by stage k-1.
  always_comb begin
    src[0]                = '0;
    src[0].a[WIDTH-1:0]   = a;
    src[0].b[WIDTH-1:0]   = b;
    src[0].carry          = cin;
    src[0].mode           = approx_en ? MODE_LOA : MODE_EXACT;
    src[0].vld            = in_valid;
    for (int k = 1; k < STAGES; k++) begin
      src[k] = st_q[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      seg_a[k]    = src[k].a[k*SEG +: SEG];
      seg_b[k]    = src[k].b[k*SEG +: SEG];
      seg_cin[k]  = src[k].carry;
      seg_mode[k] = src[k].mode;
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_seg
    adder_seg #(
      .SEG        (SEG),
      .BASE       (k * SEG),
      .APPROX_BITS(APPROX_BITS)
    ) u_seg (
      .a_seg(seg_a[k]),
      .b_seg(seg_b[k]),
      .cin  (seg_cin[k]),
      .mode (seg_mode[k]),
      .s_seg(seg_s[k]),
      .cout (seg_cout[k])
    );
  end

  always_comb begin
    adv       = '0;
    adv[LAST] = !st_q[LAST].vld || out_ready;
    for (int k = LAST - 1; k >= 0; k--) begin
      adv[k] = !st_q[k].vld || adv[k+1];
    end
  end

  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      st_d[k] = st_q[k];
      if (adv[k]) begin
        st_d[k]                  = src[k];
        st_d[k].y[k*SEG +: SEG]  = seg_s[k];
        st_d[k].carry            = seg_cout[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) st_q[k] <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) st_q[k] <= st_d[k];
    end
  end

  assign in_ready  = adv[0];
  assign out_valid = st_q[LAST].vld;
  assign y         = st_q[LAST].y[WIDTH-1:0];
  assign cout      = st_q[LAST].carry;

endmodule

// File: tb/tb_pipe_approx_adder.sv
// Directed and scoreboarded checks of pipe_approx_adder in 16/2/4 and 32/4/9 configurations.
module tb_pipe_approx_adder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        h_in_valid, h_in_ready, h_cin, h_approx_en, h_out_valid, h_out_ready, h_cout;
  logic [15:0] h_a, h_b, h_y;
  logic        w_in_valid, w_in_ready, w_cin, w_approx_en, w_out_valid, w_out_ready, w_cout;
  logic [31:0] w_a, w_b, w_y;

  int n_checks = 0;
  int n_fail   = 0;

  pipe_approx_adder #(.WIDTH(16), .STAGES(2), .APPROX_BITS(4)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(h_in_valid), .in_ready(h_in_ready),
    .a(h_a), .b(h_b), .cin(h_cin), .approx_en(h_approx_en),
    .out_valid(h_out_valid), .out_ready(h_out_ready), .y(h_y), .cout(h_cout)
  );

  pipe_approx_adder #(.WIDTH(32), .STAGES(4), .APPROX_BITS(9)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(w_in_valid), .in_ready(w_in_ready),
    .a(w_a), .b(w_b), .cin(w_cin), .approx_en(w_approx_en),
    .out_valid(w_out_valid), .out_ready(w_out_ready), .y(w_y), .cout(w_cout)
  );

  task automatic check(input string tag, input logic [64:0] got, input logic [64:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: OR the low k bits, add the upper parts with carry a[k-1]&b[k-1].
  function automatic logic [64:0] ref_add(input int w, input int k, input logic [63:0] a,
                                          input logic [63:0] b, input logic cin, input logic loa);
    logic [64:0] ea, eb, full, lowm, hi, ymask, tmp;
    ea = {1'b0, a};
    eb = {1'b0, b};
    if (!loa || k == 0) begin
      full = ea + eb + 65'(cin);
    end else begin
      lowm = (65'd1 << k) - 65'd1;
      hi   = (ea >> k) + (eb >> k) + 65'(a[k-1] & b[k-1]);
      full = (hi << k) | ((ea | eb) & lowm);
    end
    ymask = (65'd1 << w) - 65'd1;
    tmp   = full & ymask;
    return {full[w], tmp[63:0]};
  endfunction

  function automatic logic [64:0] mk(input logic c, input logic [63:0] v);
    return {c, v};
  endfunction

  function automatic logic [64:0] h_res();
    return {h_cout, 48'd0, h_y};
  endfunction

  function automatic logic [64:0] w_res();
    return {w_cout, 32'd0, w_y};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Operands must stay valid and stable until accepted.
  logic        h_pend = 1'b0, w_pend = 1'b0;
  logic [15:0] h_pa, h_pb;
  logic [31:0] w_pa, w_pb;
  logic        h_pc, h_pm, w_pc, w_pm;
  always @(posedge clk) begin
    if (rst_n && h_pend)
      assert (h_in_valid && h_a == h_pa && h_b == h_pb && h_cin == h_pc && h_approx_en == h_pm)
        else $error("dut16 input changed while stalled");
    if (rst_n && w_pend)
      assert (w_in_valid && w_a == w_pa && w_b == w_pb && w_cin == w_pc && w_approx_en == w_pm)
        else $error("dut32 input changed while stalled");
    h_pend <= h_in_valid && !h_in_ready;
    h_pa <= h_a; h_pb <= h_b; h_pc <= h_cin; h_pm <= h_approx_en;
    w_pend <= w_in_valid && !w_in_ready;
    w_pa <= w_a; w_pb <= w_b; w_pc <= w_cin; w_pm <= w_approx_en;
  end

  task automatic h_drive(input logic [15:0] a, input logic [15:0] b, input logic c, input logic m);
    h_a = a; h_b = b; h_cin = c; h_approx_en = m; h_in_valid = 1'b1;
  endtask

  task automatic single(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic c, input logic m, input logic [64:0] exp);
    h_out_ready = 1'b1;
    h_drive(a, b, c, m);
    #1;
    check({tag, "_rdy"}, 65'(h_in_ready), 65'd1);
    step();
    h_in_valid = 1'b0;
    check({tag, "_lat1"}, 65'(h_out_valid), 65'd0);
    step();
    check({tag, "_vld"}, 65'(h_out_valid), 65'd1);
    check(tag, h_res(), exp);
    step();
    check({tag, "_drain"}, 65'(h_out_valid), 65'd0);
  endtask

  logic [15:0] sa [8] = '{16'hFFFF, 16'h000F, 16'h1234, 16'h8008, 16'h7FFF, 16'h00F0, 16'hABCD, 16'hFFF8};
  logic [15:0] sb [8] = '{16'h0001, 16'h0001, 16'h4321, 16'h8008, 16'h0001, 16'h000F, 16'h5432, 16'h0008};
  logic        sc [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

  localparam int N_RND = 40;
  logic [31:0] ra [N_RND];
  logic [31:0] rb [N_RND];
  logic        rc [N_RND];
  logic        rm [N_RND];

  initial begin
    logic [64:0] bp_exp [3];
    int idx, got, cyc;
    logic acc, oacc;

    h_in_valid = 0; h_a = 0; h_b = 0; h_cin = 0; h_approx_en = 0; h_out_ready = 0;
    w_in_valid = 0; w_a = 0; w_b = 0; w_cin = 0; w_approx_en = 0; w_out_ready = 1;
    rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    #1;
    check("rst_out_valid", 65'(h_out_valid), 65'd0);
    check("rst_y_cout", h_res(), 65'd0);
    check("rst_in_ready", 65'(h_in_ready), 65'd1);

    single("exact_wrap",    16'hFFFF, 16'h0001, 1'b0, 1'b0, mk(1'b1, 64'h0000));
    single("loa_nocarry",   16'h000F, 16'h0001, 1'b0, 1'b1, mk(1'b0, 64'h000F));
    single("loa_carry_cin", 16'h0008, 16'h0008, 1'b1, 1'b1, mk(1'b0, 64'h0018));
    single("exact_cin",     16'h1234, 16'h0FCB, 1'b1, 1'b0, mk(1'b0, 64'h2200));
    single("exact_segcar",  16'h00FF, 16'h0001, 1'b0, 1'b0, mk(1'b0, 64'h0100));
    single("loa_segcar",    16'h00F8, 16'h0008, 1'b0, 1'b1, mk(1'b0, 64'h0108));
    single("loa_cout",      16'hFFF8, 16'h0008, 1'b0, 1'b1, mk(1'b1, 64'h0008));

    // Back-to-back stream with alternating modes.
    h_out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (c < 8) h_drive(sa[c], sb[c], sc[c], 1'(c % 2));
      else h_in_valid = 1'b0;
      #1;
      if (c < 8) check($sformatf("stream_rdy%0d", c), 65'(h_in_ready), 65'd1);
      step();
      if (c >= 1 && c <= 8) begin
        check($sformatf("stream_vld%0d", c - 1), 65'(h_out_valid), 65'd1);
        check($sformatf("stream_dat%0d", c - 1), h_res(),
              ref_add(16, 4, 64'(sa[c-1]), 64'(sb[c-1]), sc[c-1], 1'((c - 1) % 2)));
      end
    end
    check("stream_empty", 65'(h_out_valid), 65'd0);

    // Backpressure: two entries fill the pipe, the third waits.
    bp_exp[0] = ref_add(16, 4, 64'h1111, 64'h2222, 1'b0, 1'b0);
    bp_exp[1] = ref_add(16, 4, 64'h00FF, 64'h0F0F, 1'b1, 1'b1);
    bp_exp[2] = ref_add(16, 4, 64'hF00F, 64'h0FF1, 1'b1, 1'b0);
    h_out_ready = 1'b0;
    h_drive(16'h1111, 16'h2222, 1'b0, 1'b0);
    #1;
    check("bp_rdy0", 65'(h_in_ready), 65'd1);
    step();
    h_drive(16'h00FF, 16'h0F0F, 1'b1, 1'b1);
    #1;
    check("bp_rdy1", 65'(h_in_ready), 65'd1);
    step();
    h_drive(16'hF00F, 16'h0FF1, 1'b1, 1'b0);
    #1;
    check("bp_full_rdy", 65'(h_in_ready), 65'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("bp_hold_rdy%0d", i), 65'(h_in_ready), 65'd0);
      check($sformatf("bp_hold_vld%0d", i), 65'(h_out_valid), 65'd1);
      check($sformatf("bp_hold_dat%0d", i), h_res(), bp_exp[0]);
    end
    h_out_ready = 1'b1;
    #1;
    check("bp_rel_rdy", 65'(h_in_ready), 65'd1);
    step();
    h_in_valid = 1'b0;
    check("bp_out1_vld", 65'(h_out_valid), 65'd1);
    check("bp_out1", h_res(), bp_exp[1]);
    step();
    check("bp_out2_vld", 65'(h_out_valid), 65'd1);
    check("bp_out2", h_res(), bp_exp[2]);
    step();
    check("bp_empty", 65'(h_out_valid), 65'd0);

    // Reset with two valid entries in flight.
    h_out_ready = 1'b0;
    h_drive(16'h4444, 16'h1111, 1'b0, 1'b0);
    step();
    h_drive(16'h0F0F, 16'h00F0, 1'b1, 1'b1);
    step();
    h_in_valid = 1'b0;
    check("rmid_pre_vld", 65'(h_out_valid), 65'd1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    #1;
    check("rmid_vld", 65'(h_out_valid), 65'd0);
    check("rmid_y_cout", h_res(), 65'd0);
    check("rmid_rdy", 65'(h_in_ready), 65'd1);
    h_out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("rmid_stale%0d", i), 65'(h_out_valid), 65'd0);
    end

    // Random sweep on the 32/4/9 instance with random backpressure.
    for (int i = 0; i < N_RND; i++) begin
      ra[i] = $urandom;
      rb[i] = $urandom;
      rc[i] = 1'($urandom_range(0, 1));
      rm[i] = 1'($urandom_range(0, 1));
    end
    ra[0] = 32'hFFFF_FFFF; rb[0] = 32'h0000_0001; rc[0] = 1'b0; rm[0] = 1'b0;
    ra[1] = 32'h0000_01FF; rb[1] = 32'h0000_0100; rc[1] = 1'b1; rm[1] = 1'b1;
    idx = 0; got = 0; cyc = 0;
    while (got < N_RND && cyc < 1000) begin
      w_in_valid = (idx < N_RND);
      if (idx < N_RND) begin
        w_a = ra[idx]; w_b = rb[idx]; w_cin = rc[idx]; w_approx_en = rm[idx];
      end
      w_out_ready = ($urandom_range(0, 3) != 0);
      #1;
      acc  = w_in_valid && w_in_ready;
      oacc = w_out_valid && w_out_ready;
      if (oacc) begin
        check($sformatf("rnd%0d", got), w_res(),
              ref_add(32, 9, 64'(ra[got]), 64'(rb[got]), rc[got], rm[got]));
        got++;
      end
      step();
      if (acc) idx++;
      cyc++;
    end
    w_in_valid = 1'b0;
    check("rnd_count", 65'(got), 65'(N_RND));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
